// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU entry sequencer and its neighbours.
// Holds the FSM state encoding, the stage encodings presented on the
// display, default widths, and the ALU operation codes, so the ALU and
// the sequencer agree on what each op value means.
package alu_seq_pkg;

    // Default widths
    localparam int DATA_W_DEF = 4;
    localparam int OP_W_DEF   = 2;
    localparam int RES_W_DEF  = 8;

    // ALU operation codes (op select values understood by the ALU)
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    // Field-under-edit encodings shown on the stage output
    localparam logic [1:0] STAGE_A   = 2'b00;
    localparam logic [1:0] STAGE_B   = 2'b01;
    localparam logic [1:0] STAGE_OP  = 2'b10;
    localparam logic [1:0] STAGE_RUN = 2'b11;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Map an FSM state to the stage code; EXEC and SHOW share one code.
    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] st;
        case (s)
            S_A:     st = STAGE_A;
            S_B:     st = STAGE_B;
            S_OP:    st = STAGE_OP;
            default: st = STAGE_RUN;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/alu_entry_sequencer_if.sv
// Bus between the entry sequencer and the ALU/display side.
//   alu_result   : combinational ALU output for the current a/b/op
//   a, b, op     : operands and operation select presented to the ALU
//   result       : latched ALU result
//   result_valid : result holds a value for the current entry
//   stage        : field under edit (00=A, 01=B, 10=OP, 11=EXEC/SHOW)
// master = sequencer side, slave = ALU/display side.
interface alu_entry_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int RES_W  = RES_W_DEF
) ();
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [RES_W-1:0]  alu_result;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic [1:0]        stage;

    modport master (
        input  alu_result,
        output a, b, op, result, result_valid, stage
    );

    modport slave (
        output alu_result,
        input  a, b, op, result, result_valid, stage
    );
endinterface

// File: rtl/alu_entry_sequencer_key_debounce.sv
// key_debounce: two-flop synchronizer, debounce counter and press pulse
// for one active-low push-button.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   key_n  : raw key, 0 = pressed
//   press  : one-cycle pulse in the cycle after the debounced state
//            falls from released to pressed; release gives no pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Synchronizer and stable state reset to "released" so a key held
    // through reset is reported as a press once it has been debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            stable_reg <= 1'b1;
            press_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                // Accept the new level; the pulse register is set in the
                // same edge so it is high in the cycle after stable falls.
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
                press_reg  <= stable_reg & ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer: single-clock controller that lets the user enter
// operand a, operand b and the op select with two keys, then holds the
// operands for a settle period and latches the ALU result for display.
//   CLOCK_50 : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   KEY[0]   : increment the field under edit (active-low)
//   KEY[1]   : advance to the next field (active-low)
//   bus      : ALU/display bus (alu_result in; a, b, op, result,
//              result_valid, stage out)
module alu_entry_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int OP_W            = OP_W_DEF,
    parameter int RES_W           = RES_W_DEF,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EXEC_CYCLES     = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [1:0]            KEY,
    alu_entry_sequencer_if.master bus
);
    localparam int SETTLE_W = $clog2(EXEC_CYCLES + 1);

    logic [1:0] press;
    logic       inc;
    logic       nxt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk   (CLOCK_50),
                .rst_n (RESET_N),
                .key_n (KEY[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    assign inc = press[0];
    assign nxt = press[1];

    state_t              state_reg,  state_next;
    logic [DATA_W-1:0]   a_reg,      a_next;
    logic [DATA_W-1:0]   b_reg,      b_next;
    logic [OP_W-1:0]     op_reg,     op_next;
    logic [RES_W-1:0]    result_reg, result_next;
    logic                valid_reg,  valid_next;
    logic [1:0]          stage_reg,  stage_next;
    logic [SETTLE_W-1:0] settle_reg, settle_next;

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        result_next = result_reg;
        valid_next  = valid_reg;
        settle_next = settle_reg;
        // next has priority over inc when both pulse together
        case (state_reg)
            S_A: begin
                if (nxt)      state_next = S_B;
                else if (inc) a_next     = a_reg + 1'b1;
            end
            S_B: begin
                if (nxt)      state_next = S_OP;
                else if (inc) b_next     = b_reg + 1'b1;
            end
            S_OP: begin
                if (nxt) begin
                    state_next  = S_EXEC;
                    settle_next = SETTLE_W'(EXEC_CYCLES);
                end else if (inc) begin
                    op_next = op_reg + 1'b1;
                end
            end
            S_EXEC: begin
                // Operands are frozen; latch on the cycle the count hits 0.
                if (settle_reg <= SETTLE_W'(1)) begin
                    settle_next = '0;
                    result_next = bus.alu_result;
                    valid_next  = 1'b1;
                    state_next  = S_SHOW;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            S_SHOW: begin
                if (nxt) begin
                    state_next = S_A;
                    valid_next = 1'b0;
                end
            end
            default: state_next = S_A;
        endcase
        stage_next = stage_of(state_next);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= S_A;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
            stage_reg  <= STAGE_A;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
            stage_reg  <= stage_next;
            settle_reg <= settle_next;
        end
    end

    assign bus.a            = a_reg;
    assign bus.b            = b_reg;
    assign bus.op           = op_reg;
    assign bus.result       = result_reg;
    assign bus.result_valid = valid_reg;
    assign bus.stage        = stage_reg;

endmodule

// File: doc/alu_entry_sequencer.md
Name: alu_entry_sequencer

Overview:
- Clocked controller that sequences operand and operation entry for the ALU from two push-buttons.
- Debounces the buttons, steps through editing a, b and op, then holds the operands for a settle period.
- Latches the ALU result and presents it with a valid flag to the display decoders.
- Sits between the board keys and the ALU/display instances, replacing edge-on-button clocking with a single-clock design.

Parameters:
- DATA_W, 4, operand width of a and b
- OP_W, 2, operation select width
- RES_W, 8, ALU result width
- DEBOUNCE_CYCLES, 500000, cycles a key must be stable before its state is accepted (10 ms at 50 MHz)
- EXEC_CYCLES, 1, cycles operands are held stable before the result is latched (≥1)

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge
- RESET_N  input  1  asynchronous, active-low reset
- KEY  input  2  raw push-buttons, active-low (0 = pressed); KEY[0] = increment, KEY[1] = next
- alu_result  input  RES_W  combinational ALU output for the current a/b/op
- a  output  DATA_W  operand A to the ALU and display
- b  output  DATA_W  operand B to the ALU and display
- op  output  OP_W  operation select to the ALU and display
- result  output  RES_W  latched result
- result_valid  output  1  result holds a latched value for the current entry
- stage  output  2  field under edit: 00=A, 01=B, 10=OP, 11=EXEC/SHOW

Behaviour:
- Reset (async assert, sync release): a=0, b=0, op=0, result=0, result_valid=0, stage=00, FSM=S_A. Synchronizers and stable key states reset to 1 (released); debounce counters reset to 0; no pulses.
- Synchronizer: two flops per key.
- Debounce, per key:
  - Counter increments while the synchronized value differs from the stable value.
  - Counter clears on any cycle where they agree.
  - When the counter reaches DEBOUNCE_CYCLES, stable takes the synchronized value and the counter clears.
- Press event: one-cycle pulse in the cycle after stable goes 1→0. Release generates nothing.
- Latency: with a key held low continuously, the edited field changes at the clock edge DEBOUNCE_CYCLES+4 edges after the first edge that samples KEY low.
- Simultaneous events: a next pulse and an inc pulse in the same cycle → next is taken, inc is discarded.
- FSM:
  - S_A: inc → a<=a+1, wrapping 4'hF→0. next → S_B.
  - S_B: inc → b<=b+1 with the same wrap. next → S_OP.
  - S_OP: inc → op<=op+1, wrapping 3→0. next → S_EXEC, settle counter loaded with EXEC_CYCLES.
  - S_EXEC: all pulses ignored; a/b/op frozen. Counter decrements each cycle. On the cycle it reaches 0: result<=alu_result, result_valid<=1, go to S_SHOW.
  - S_SHOW: inc ignored. next → S_A and result_valid<=0; result keeps its old value.
- Operands are never cleared except by reset.
- stage is a registered decode of the FSM state and updates in the same cycle as the state.
- Arithmetic: increments are modulo 2^width, with no saturation. result is captured verbatim at RES_W bits.
- Reset mid-operation: immediate return to reset values, including from S_EXEC, where no result is latched.
- A key held through reset release is seen as a press after debounce, since stable resets to released.
- Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.

Decomposition:
- Package alu_seq_pkg holds:
  - FSM state enum (S_A, S_B, S_OP, S_EXEC, S_SHOW)
  - stage encodings STAGE_A/B/OP/RUN
  - width constants
  - ALU op code constants shared with the ALU
- One sub-module, key_debounce: synchronizer, debounce counter and falling-edge pulse for one key, parameterized by DEBOUNCE_CYCLES. Instantiated twice.
- FSM and datapath registers stay in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=4, EXEC_CYCLES=2):
- Reset, then KEY[0] pressed 3 times (each held 10 cycles, released 10) → a=3, stage=00. Then KEY[1], KEY[0]×2, KEY[1], KEY[0], KEY[1] with the ALU modelled as add → b=2, op=1; result=5 and result_valid=1 exactly 2 cycles after S_EXEC entry; stage=11.
- Wrap: from a=15, one KEY[0] press → a=0. In S_OP from op=3, one press → op=0.
- Bounce: KEY[0] toggled low/high every 2 cycles for 20 cycles, then held high → a unchanged. Held low 20 cycles → a increments exactly once, at edge 8 after the first low sample.
- Simultaneous: both keys debounced in the same cycle while in S_A with a=5 → stage=01, a stays 5.
- Ignore and return: KEY[0] during S_EXEC and S_SHOW → no operand change. KEY[1] in S_SHOW → stage=00, result_valid=0, result unchanged.
- Async reset: RESET_N pulsed low between clock edges while in S_EXEC → all outputs 0 and stage=00 immediately, before the next edge; no result latched.
